// File: rtl/ram_word_rw.sv
// Word-to-byte RAM adapter: one DATA_WIDTH word per request, moved as NBYTES
// little-endian byte accesses on a registered byte-wide RAM port.
// Latency: write rsp at cycle NBYTES+1, read rsp at NBYTES+READ_LATENCY+1 after accept.
// Backpressure: req_ready is high only in IDLE; requests are not queued.
// Optional feature: define RAM_WORD_RW_BYTE_MASK_EN to add the req_be write mask.
// Reset is synchronous, active low; a reset mid-transaction abandons it.

module ram_word_rw #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 19,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef RAM_WORD_RW_BYTE_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] req_be,
`endif
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [7:0]              ram_writedata,
  output logic                    ram_write_enable,
  input  logic [7:0]              ram_readdata
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Per-byte enable of the incoming request; without the mask feature every byte is written.
  logic [NBYTES-1:0] req_mask;
`ifdef RAM_WORD_RW_BYTE_MASK_EN
  assign req_mask = req_be;
`else
  assign req_mask = '1;
`endif

  logic [DATA_WIDTH-1:0]   wdata_q;   // bytes still to be written, next one in [7:0]
  logic [NBYTES-1:0]       be_q;      // matching enables, next one in bit 0
  logic [IDX_W-1:0]        iss_idx;   // byte currently on the RAM port
  logic [IDX_W-1:0]        cap_idx;   // next read byte to be captured
  logic [READ_LATENCY-1:0] rd_pipe;   // marks cycles whose RAM address was a read
  logic [DATA_WIDTH-1:0]   rd_buf;    // partially assembled read word
  logic [DATA_WIDTH-1:0]   rd_buf_nxt;

  logic accept;
  logic iss_last;
  logic cap_vld;
  logic cap_last;

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    iss_last  = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b1;
    cap_vld   = rd_pipe[READ_LATENCY-1];
    cap_last  = rd_pipe[READ_LATENCY-1] && (cap_idx == LAST_IDX);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = req_write ? WR : RD_ISSUE;
        end
      end
      WR: begin
        if (iss_idx == LAST_IDX) begin
          iss_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_ISSUE: begin
        if (iss_idx == LAST_IDX) begin
          iss_last  = 1'b1;
          state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        // The final capture always lands here because READ_LATENCY >= 1.
        if (cap_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read-word assembly: drop the arriving byte into its lane.
  always_comb begin
    rd_buf_nxt = rd_buf;
    if (cap_vld) begin
      rd_buf_nxt[{cap_idx, 3'b000} +: 8] = ram_readdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture and the registered byte-RAM port; the port holds its value while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_address      <= '0;
      ram_writedata    <= '0;
      ram_write_enable <= 1'b0;
      wdata_q          <= '0;
      be_q             <= '0;
      iss_idx          <= '0;
    end else if (accept) begin
      ram_address <= req_addr;
      iss_idx     <= '0;
      if (req_write) begin
        ram_writedata    <= req_wdata[7:0];
        ram_write_enable <= req_mask[0];
        wdata_q          <= req_wdata >> 8;
        be_q             <= req_mask >> 1;
      end else begin
        ram_write_enable <= 1'b0;
      end
    end else if (state == WR || state == RD_ISSUE) begin
      if (iss_last) begin
        ram_write_enable <= 1'b0;
      end else begin
        // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
        ram_address <= ram_address + ADDR_WIDTH'(1);
        iss_idx     <= iss_idx + IDX_W'(1);
        if (state == WR) begin
          ram_writedata    <= wdata_q[7:0];
          ram_write_enable <= be_q[0];
          wdata_q          <= wdata_q >> 8;
          be_q             <= be_q >> 1;
        end
      end
    end
  end

  // Read-return tracking, byte capture and the completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe   <= '0;
      cap_idx   <= '0;
      rd_buf    <= '0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rd_pipe[0] <= (state == RD_ISSUE);
      for (int k = 1; k < READ_LATENCY; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
      end
      rsp_valid <= ((state == WR) && iss_last) || cap_last;
      if (cap_vld) begin
        rd_buf  <= rd_buf_nxt;
        cap_idx <= cap_last ? '0 : cap_idx + IDX_W'(1);
        if (cap_last) begin
          rsp_rdata <= rd_buf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_word_rw.sv
// Bench for ram_word_rw: three instances (32-bit/RL2, 64-bit/RL1, 8-bit/RL1),
// byte RAM models on each port, expected traffic derived from the word-level rules
// and a byte-addressed shadow memory.

module tb_ram_word_rw;

  localparam int AW = 19, DW = 32, NB = 4, RL = 2;
  localparam int BAW = 12, BDW = 64, BNB = 8;
  localparam int CAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: default widths, READ_LATENCY=2
  logic          a_req_valid, a_req_ready, a_req_write;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic [NB-1:0] a_req_be;
  logic          a_rsp_valid, a_busy, a_ram_we;
  logic [DW-1:0] a_rsp_rdata;
  logic [AW-1:0] a_ram_address;
  logic [7:0]    a_ram_writedata, a_ram_readdata;

  ram_word_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
`ifdef RAM_WORD_RW_BYTE_MASK_EN
    .req_be(a_req_be),
`endif
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .busy(a_busy),
    .ram_address(a_ram_address), .ram_writedata(a_ram_writedata),
    .ram_write_enable(a_ram_we), .ram_readdata(a_ram_readdata)
  );

  // Byte RAM with READ_LATENCY-cycle read pipe.
  bit [7:0]   ram_a [int];
  logic [7:0] dpipe_a [RL];
  always @(posedge clk) begin
    dpipe_a[0] <= ram_a.exists(int'(a_ram_address)) ? ram_a[int'(a_ram_address)] : 8'h00;
    for (int j = 1; j < RL; j++) dpipe_a[j] <= dpipe_a[j-1];
    if (a_ram_we === 1'b1) ram_a[int'(a_ram_address)] = a_ram_writedata;
  end
  assign a_ram_readdata = dpipe_a[RL-1];

  // Shadow memory: what the RAM must contain according to the word-level rules.
  bit [7:0]      model_a [int];
  logic [DW-1:0] last_rd_exp;

  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] base);
    logic [DW-1:0] w;
    int a;
    w = '0;
    for (int k = 0; k < NB; k++) begin
      a = int'(AW'(base + k));
      w[8*k +: 8] = model_a.exists(a) ? model_a[a] : 8'h00;
    end
    return w;
  endfunction

  // ---------------- instance B: 64-bit word, READ_LATENCY=1, writes only
  logic           b_req_valid, b_req_ready, b_req_write;
  logic [BAW-1:0] b_req_addr;
  logic [BDW-1:0] b_req_wdata;
  logic [BNB-1:0] b_req_be;
  logic           b_rsp_valid, b_busy, b_ram_we;
  logic [BDW-1:0] b_rsp_rdata;
  logic [BAW-1:0] b_ram_address;
  logic [7:0]     b_ram_writedata;

  ram_word_rw #(.DATA_WIDTH(BDW), .ADDR_WIDTH(BAW), .READ_LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
`ifdef RAM_WORD_RW_BYTE_MASK_EN
    .req_be(b_req_be),
`endif
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .ram_address(b_ram_address), .ram_writedata(b_ram_writedata),
    .ram_write_enable(b_ram_we), .ram_readdata(8'h00)
  );

  // ---------------- instance C: single-byte word, READ_LATENCY=1
  logic           c_req_valid, c_req_ready, c_req_write;
  logic [CAW-1:0] c_req_addr;
  logic [7:0]     c_req_wdata;
  logic [0:0]     c_req_be;
  logic           c_rsp_valid, c_busy, c_ram_we;
  logic [7:0]     c_rsp_rdata;
  logic [CAW-1:0] c_ram_address;
  logic [7:0]     c_ram_writedata, c_ram_readdata;

  ram_word_rw #(.DATA_WIDTH(8), .ADDR_WIDTH(CAW), .READ_LATENCY(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_write(c_req_write),
    .req_addr(c_req_addr), .req_wdata(c_req_wdata),
`ifdef RAM_WORD_RW_BYTE_MASK_EN
    .req_be(c_req_be),
`endif
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .busy(c_busy),
    .ram_address(c_ram_address), .ram_writedata(c_ram_writedata),
    .ram_write_enable(c_ram_we), .ram_readdata(c_ram_readdata)
  );

  logic [7:0] mem_c [256];
  always @(posedge clk) begin
    c_ram_readdata <= mem_c[c_ram_address];
    if (c_ram_we === 1'b1) mem_c[c_ram_address] = c_ram_writedata;
  end

  // ---------------- scenario tasks (each starts and ends at a negedge)

  task automatic scramble_a();
    a_req_valid = 1'b0;
    a_req_write = 1'($urandom);
    a_req_addr  = AW'($urandom);
    a_req_wdata = $urandom;
    a_req_be    = NB'($urandom);
  endtask

  task automatic run_write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [NB-1:0] be_in);
    logic [NB-1:0] be;
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    be = be_in;
`ifndef RAM_WORD_RW_BYTE_MASK_EN
    be = '1;
`endif
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = addr;
    a_req_wdata = data; a_req_be = be_in;
    n_tests++;
    if (a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_ready addr=%h: got %b expected 1", addr, a_req_ready);
    end
    @(posedge clk); @(negedge clk);
    scramble_a();
    for (int k = 0; k < NB; k++) begin
      ea = AW'(addr + k);
      ed = data[8*k +: 8];
      n_tests++;
      if ({a_ram_address, a_ram_we, a_rsp_valid, a_req_ready} !== {ea, be[k], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_byte%0d addr/we/rsp/rdy: got %h/%b/%b/%b expected %h/%b/0/0",
                 k, a_ram_address, a_ram_we, a_rsp_valid, a_req_ready, ea, be[k]);
      end
      if (be[k]) begin
        n_tests++;
        if (a_ram_writedata !== ed) begin
          n_fail++; $display("FAIL wr_data%0d: got %h expected %h", k, a_ram_writedata, ed);
        end
        model_a[int'(ea)] = ed;
      end
      @(negedge clk);
    end
    n_tests++;
    if ({a_rsp_valid, a_req_ready, a_ram_we} !== 3'b110) begin
      n_fail++; $display("FAIL wr_rsp rsp/rdy/we: got %b%b%b expected 110",
                         a_rsp_valid, a_req_ready, a_ram_we);
    end
  endtask

  task automatic run_read_a(input logic [AW-1:0] addr);
    logic [DW-1:0] exp_w;
    logic [AW-1:0] ea;
    exp_w = model_word(addr);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = addr; a_req_be = NB'($urandom);
    n_tests++;
    if (a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_ready addr=%h: got %b expected 1", addr, a_req_ready);
    end
    @(posedge clk); @(negedge clk);
    scramble_a();
    for (int k = 0; k < NB + RL; k++) begin
      ea = (k < NB) ? AW'(addr + k) : AW'(addr + NB - 1);
      n_tests++;
      if ({a_ram_address, a_ram_we, a_rsp_valid, a_busy, a_rsp_rdata} !==
          {ea, 1'b0, 1'b0, 1'b1, last_rd_exp}) begin
        n_fail++;
        $display("FAIL rd_cycle%0d addr/we/rsp/busy/rdata: got %h/%b/%b/%b/%h expected %h/0/0/1/%h",
                 k + 1, a_ram_address, a_ram_we, a_rsp_valid, a_busy, a_rsp_rdata, ea, last_rd_exp);
      end
      @(negedge clk);
    end
    last_rd_exp = exp_w;
    n_tests++;
    if ({a_rsp_valid, a_req_ready, a_rsp_rdata} !== {2'b11, exp_w}) begin
      n_fail++; $display("FAIL rd_rsp addr=%h rsp/rdy/rdata: got %b/%b/%h expected 1/1/%h",
                         addr, a_rsp_valid, a_req_ready, a_rsp_rdata, exp_w);
    end
  endtask

  task automatic run_write_b(input logic [BAW-1:0] addr, input logic [BDW-1:0] data);
    logic [BAW-1:0] ea;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = addr; b_req_wdata = data; b_req_be = '1;
    n_tests++;
    if (b_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b_ready addr=%h: got %b expected 1", addr, b_req_ready);
    end
    @(posedge clk); @(negedge clk);
    b_req_valid = 1'b0; b_req_addr = BAW'($urandom); b_req_wdata = {$urandom, $urandom};
    for (int k = 0; k < BNB; k++) begin
      ea = BAW'(addr + k);
      n_tests++;
      if ({b_ram_address, b_ram_writedata, b_ram_we, b_rsp_valid} !== {ea, data[8*k +: 8], 2'b10}) begin
        n_fail++;
        $display("FAIL b_byte%0d addr/data/we/rsp: got %h/%h/%b/%b expected %h/%h/1/0",
                 k, b_ram_address, b_ram_writedata, b_ram_we, b_rsp_valid, ea, data[8*k +: 8]);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({b_rsp_valid, b_req_ready, b_ram_we} !== 3'b110) begin
      n_fail++; $display("FAIL b_rsp rsp/rdy/we: got %b%b%b expected 110",
                         b_rsp_valid, b_req_ready, b_ram_we);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_rd_exp = '0;
    @(negedge clk);
    n_tests++;
    if ({a_req_ready, a_busy, a_rsp_valid, a_ram_we} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl rdy/busy/rsp/we: got %b%b%b%b expected 1000",
                         a_req_ready, a_busy, a_rsp_valid, a_ram_we);
    end
    n_tests++;
    if ({a_ram_address, a_ram_writedata, a_rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data addr/wdata/rdata: got %h/%h/%h expected 0/0/0",
                         a_ram_address, a_ram_writedata, a_rsp_rdata);
    end
    n_tests++;
    if ({b_req_ready, b_ram_we, b_rsp_valid, c_req_ready, c_ram_we, c_rsp_valid} !== 6'b100100) begin
      n_fail++; $display("FAIL reset_bc: got %b%b%b%b%b%b expected 100100",
                         b_req_ready, b_ram_we, b_rsp_valid, c_req_ready, c_ram_we, c_rsp_valid);
    end
  endtask

  task automatic test_basic_rw();
    run_write_a(19'h00100, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    run_read_a(19'h00100);
    n_tests++;
    if (a_rsp_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL readback_const: got %h expected deadbeef", a_rsp_rdata);
    end
  endtask

  task automatic test_wrap();
    run_write_a(19'h7FFFE, 32'h11223344, 4'hF);
    run_read_a(19'h7FFFE);
    run_read_a(19'h00000);
  endtask

  task automatic test_byte_mask();
    run_write_a(19'h00200, 32'h01020304, 4'hF);
    run_write_a(19'h00200, 32'hAABBCCDD, 4'b0101);
    run_read_a(19'h00200);
    run_write_a(19'h00300, 32'h55667788, 4'hF);
    run_write_a(19'h00300, 32'h99999999, 4'b0000);
    run_read_a(19'h00300);
    // Reads ignore whatever mask happens to be on req_be.
    a_req_be = 4'b0000;
    run_read_a(19'h00200);
  endtask

  task automatic test_reset_mid_write();
    logic [DW-1:0] data;
    data = $urandom;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 19'h00400; a_req_wdata = data; a_req_be = '1;
    @(posedge clk); @(negedge clk);
    scramble_a();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({a_ram_address, a_ram_we} !== {AW'(19'h00400 + k), 1'b1}) begin
        n_fail++; $display("FAIL rstw_byte%0d addr/we: got %h/%b", k, a_ram_address, a_ram_we);
      end
      model_a[int'(AW'(19'h00400 + k))] = data[8*k +: 8];
      if (k == 1) rst_n = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    last_rd_exp = '0;
    for (int k = 0; k < NB + 2; k++) begin
      n_tests++;
      if ({a_ram_we, a_rsp_valid, a_req_ready} !== 3'b001) begin
        n_fail++; $display("FAIL rstw_after%0d we/rsp/rdy: got %b%b%b expected 001",
                           k, a_ram_we, a_rsp_valid, a_req_ready);
      end
      @(negedge clk);
    end
    run_write_a(19'h00410, $urandom, 4'hF);
    run_read_a(19'h00400);
  endtask

  task automatic test_reset_mid_read();
    run_write_a(19'h00500, $urandom, 4'hF);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 19'h00500;
    @(posedge clk); @(negedge clk);
    scramble_a();
    repeat (NB) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd_exp = '0;
    for (int k = 0; k < 2 * RL + 2; k++) begin
      n_tests++;
      if ({a_rsp_valid, a_rsp_rdata} !== {1'b0, 32'h0}) begin
        n_fail++; $display("FAIL rstr_after%0d rsp/rdata: got %b/%h expected 0/0",
                           k, a_rsp_valid, a_rsp_rdata);
      end
      @(negedge clk);
    end
    run_read_a(19'h00500);
  endtask

  task automatic test_random();
    logic [AW-1:0] addr;
    for (int i = 0; i < 40; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? AW'(19'h7FFFC + $urandom_range(0, 7))
                                          : AW'(19'h00600 + $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) run_write_a(addr, $urandom, NB'($urandom));
      else                            run_read_a(addr);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    run_write_b(12'hFFC, 64'h0807060504030201);
    run_write_b(12'h010, {$urandom, $urandom});
    @(negedge clk);
    n_tests++;
    if ({b_rsp_valid, b_ram_we, b_busy} !== 3'b000) begin
      n_fail++; $display("FAIL b_idle rsp/we/busy: got %b%b%b expected 000", b_rsp_valid, b_ram_we, b_busy);
    end
  endtask

  task automatic test_single_byte();
    c_req_valid = 1'b1; c_req_write = 1'b1; c_req_addr = 8'h7F; c_req_wdata = 8'h5A; c_req_be = 1'b1;
    @(posedge clk); @(negedge clk);
    c_req_valid = 1'b0; c_req_addr = 8'h00; c_req_wdata = 8'hFF;
    n_tests++;
    if ({c_ram_address, c_ram_writedata, c_ram_we, c_rsp_valid} !== {8'h7F, 8'h5A, 2'b10}) begin
      n_fail++; $display("FAIL c_wr addr/data/we/rsp: got %h/%h/%b/%b expected 7f/5a/1/0",
                         c_ram_address, c_ram_writedata, c_ram_we, c_rsp_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({c_rsp_valid, c_req_ready, c_ram_we} !== 3'b110) begin
      n_fail++; $display("FAIL c_wr_rsp: got %b%b%b expected 110", c_rsp_valid, c_req_ready, c_ram_we);
    end
    c_req_valid = 1'b1; c_req_write = 1'b0; c_req_addr = 8'h7F;
    @(posedge clk); @(negedge clk);
    c_req_valid = 1'b0;
    n_tests++;
    if ({c_ram_address, c_ram_we, c_rsp_valid} !== {8'h7F, 2'b00}) begin
      n_fail++; $display("FAIL c_rd_issue: got %h/%b/%b expected 7f/0/0", c_ram_address, c_ram_we, c_rsp_valid);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({c_rsp_valid, c_rsp_rdata} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL c_rd_rsp: got %b/%h expected 1/5a", c_rsp_valid, c_rsp_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_c[i] = 8'h00;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '1;
    c_req_valid = 1'b0; c_req_write = 1'b0; c_req_addr = '0; c_req_wdata = '0; c_req_be = 1'b1;
    last_rd_exp = '0;
    @(negedge clk);
    test_reset();
    test_basic_rw();
    test_wrap();
    test_byte_mask();
    test_reset_mid_write();
    test_reset_mid_read();
    test_random();
    test_back_to_back();
    test_single_byte();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within the time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_word_rw.md
RAM_WORD_RW -- requirements
Module: ram_word_rw

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8 and at least 8; NBYTES = DATA_WIDTH/8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 19, byte-address width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, RAM read latency in cycles; legal range 1..4.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all logic on posedge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block accepts a request; high exactly when the FSM is in IDLE.
REQ-009 req_write  in  1  1 = write word, 0 = read word.
REQ-010 req_addr  in  ADDR_WIDTH  base byte address.
REQ-011 req_wdata  in  DATA_WIDTH  write word.
REQ-012 req_be  in  NBYTES  per-byte write mask; present only with BYTE_MASK_EN.
REQ-013 rsp_valid  out  1  one-cycle completion pulse for reads and writes.
REQ-014 rsp_rdata  out  DATA_WIDTH  assembled read word; holds until the next read completes.
REQ-015 busy  out  1  transaction in flight (FSM not in IDLE).
REQ-016 ram_address, ram_writedata, ram_write_enable  out  ADDR_WIDTH/8/1  registered byte-RAM port.
REQ-017 ram_readdata  in  8  RAM read byte, valid READ_LATENCY cycles after its address.

Function
REQ-018 Accept SHALL occur on a cycle with req_valid and req_ready both high; address, data, mode and mask SHALL be captured on that cycle; later input changes SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, WR, RD_ISSUE and RD_DRAIN; transitions: IDLE->WR or IDLE->RD_ISSUE on accept, WR->IDLE after byte NBYTES-1, RD_ISSUE->RD_DRAIN after byte NBYTES-1, RD_DRAIN->IDLE after the last byte is captured.
REQ-020 Byte i (i = 0..NBYTES-1) SHALL map to data[8i+7:8i] at address (base+i) mod 2^ADDR_WIDTH (little-endian; wraps past the top address).
REQ-021 Write: with accept at cycle 0, cycles 1..NBYTES SHALL drive byte i with ram_write_enable=1; rsp_valid SHALL pulse at cycle NBYTES+1, the same cycle req_ready returns high.
REQ-022 Read: cycles 1..NBYTES SHALL drive address i with ram_write_enable=0; byte i SHALL be sampled READ_LATENCY cycles after its address cycle; rsp_valid and the updated rsp_rdata SHALL appear at cycle NBYTES+READ_LATENCY+1.
REQ-023 ram_write_enable SHALL be 0 in every cycle outside WR; ram_address and ram_writedata SHALL hold their last value while IDLE.
REQ-024 A request presented on the rsp_valid cycle SHALL be accepted (back-to-back operation; throughput is one word per NBYTES+1 cycles for writes).
REQ-025 NBYTES=1 SHALL be legal and behave as a single-byte transaction.

Reset
REQ-026 With rst_n low at a clock edge, the block SHALL enter IDLE, set rsp_valid, ram_write_enable and busy to 0, and set ram_address, ram_writedata and rsp_rdata to 0; req_ready SHALL be 1 on the first cycle after reset releases.
REQ-027 Reset mid-transaction SHALL abandon it: no further RAM writes and no rsp_valid for it; read bytes still in flight SHALL be discarded.

Configuration
REQ-028 Macro RAM_WORD_RW_BYTE_MASK_EN: when defined, the req_be port SHALL exist; in a write, a byte with req_be[i]=0 SHALL keep its address slot but drive ram_write_enable=0, and timing SHALL be unchanged; an all-zero mask SHALL still complete with rsp_valid at cycle NBYTES+1; reads SHALL ignore req_be.
REQ-029 When the macro is undefined, req_be SHALL be absent and all bytes SHALL be written.

Verification
REQ-030 Default params; write addr 0x00100, data 0xDEADBEEF -> bytes EF,BE,AD,DE at 0x00100..0x00103 in cycles 1..4; rsp_valid at cycle 5.
REQ-031 Read back addr 0x00100 with READ_LATENCY=2 against a RAM model -> rsp_rdata=0xDEADBEEF with rsp_valid at cycle 7.
REQ-032 Write at addr 0x7FFFE, data 0x11223344 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-033 Macro defined, req_be=4'b0101, data 0xAABBCCDD -> only DD at base+0 and BB at base+2 written; write-enable low in cycles 2 and 4.
REQ-034 rst_n low at cycle 2 of a write -> no more write pulses, no rsp_valid, req_ready=1 after release; a new request is then accepted normally.
REQ-035 DATA_WIDTH=64, back-to-back writes issued on the rsp_valid cycle -> 8 byte writes each, no idle gap between the two transactions.
